spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 146 ++++++++++++++
 tb/tb_spi_reg_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: byte-command register bridge behind an SPI slave.
// Six read/write registers (0-5) plus two read-only status bytes (6-7).
// Command byte: bit7 = write, bits 6:3 must be zero, bits 2:0 = address.
// Optional feature macro SPI_REG_AUTOINC_EN: burst access with address
// auto-increment; when undefined, one data byte per command.
module spi_reg_bridge #(
  parameter logic [47:0] REG_RESET = 48'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ssel,
  input  logic [7:0]  cmd,
  input  logic        cmd_valid,
  output logic [7:0]  response,
  input  logic [15:0] status_in,
  output logic [47:0] reg_out,
  output logic [5:0]  wr_strobe
);

  localparam int unsigned NUM_RW_REGS = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_DATA = 2'd2,
    SKIP    = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_addr;
  logic [7:0]  r_response;
  logic [47:0] r_regs;
  logic [5:0]  r_wr_strobe;
  logic        r_ssel_meta;
  logic        r_ssel_sync;
  logic        r_ssel_dly;

  logic        w_frame_end;
  logic        w_cmd_ok;
`ifdef SPI_REG_AUTOINC_EN
  logic [2:0]  w_addr_nxt;
`endif

  // Byte visible at a read address; 6 and 7 are the live status inputs.
  function automatic logic [7:0] f_rd_byte(input logic [2:0]  a,
                                           input logic [47:0] regs,
                                           input logic [15:0] st);
    case (a)
      3'd0:    f_rd_byte = regs[7:0];
      3'd1:    f_rd_byte = regs[15:8];
      3'd2:    f_rd_byte = regs[23:16];
      3'd3:    f_rd_byte = regs[31:24];
      3'd4:    f_rd_byte = regs[39:32];
      3'd5:    f_rd_byte = regs[47:40];
      3'd6:    f_rd_byte = st[7:0];
      default: f_rd_byte = st[15:8];
    endcase
  endfunction

  // Rising edge of the synchronised chip select closes the frame.
  assign w_frame_end = r_ssel_sync & ~r_ssel_dly;
  assign w_cmd_ok    = (cmd[6:3] == 4'h0);
`ifdef SPI_REG_AUTOINC_EN
  assign w_addr_nxt  = r_addr + 3'd1;
`endif

  // Two-flop synchroniser for ssel plus a delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ssel_meta <= 1'b1;
      r_ssel_sync <= 1'b1;
      r_ssel_dly  <= 1'b1;
    end else begin
      r_ssel_meta <= ssel;
      r_ssel_sync <= r_ssel_meta;
      r_ssel_dly  <= r_ssel_sync;
    end
  end

  // Command FSM with registered response, register file and write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= 3'd0;
      r_response  <= 8'h00;
      r_regs      <= REG_RESET;
      r_wr_strobe <= '0;
    end else begin
      r_wr_strobe <= '0;
      if (w_frame_end) begin
        // Frame end beats a coincident byte: nothing is written.
        r_state    <= IDLE;
        r_response <= 8'h00;
      end else if (cmd_valid) begin
        case (r_state)
          IDLE: begin
            if (!w_cmd_ok) begin
              r_state    <= SKIP;
              r_response <= 8'hEE;
            end else begin
              r_addr <= cmd[2:0];
              if (cmd[7]) begin
                r_state    <= WR_DATA;
                r_response <= 8'h00;
              end else begin
                r_state    <= RD_DATA;
                r_response <= f_rd_byte(cmd[2:0], r_regs, status_in);
              end
            end
          end
          WR_DATA: begin
            if (r_addr < 3'(NUM_RW_REGS)) begin
              for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (r_addr == 3'(i)) r_regs[8*i +: 8] <= cmd;
              end
              r_wr_strobe <= 6'b000001 << r_addr;
            end
`ifdef SPI_REG_AUTOINC_EN
            r_addr <= w_addr_nxt;
`else
            r_state    <= SKIP;
            r_response <= 8'h00;
`endif
          end
          RD_DATA: begin
`ifdef SPI_REG_AUTOINC_EN
            r_addr     <= w_addr_nxt;
            r_response <= f_rd_byte(w_addr_nxt, r_regs, status_in);
`else
            r_state    <= SKIP;
            r_response <= 8'h00;
`endif
          end
          default: begin
            // SKIP: bytes ignored, response held.
          end
        endcase
      end
    end
  end

  assign response  = r_response;
  assign reg_out   = r_regs;
  assign wr_strobe = r_wr_strobe;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed checks of spi_reg_bridge with hand-computed
// expectations; expectations follow SPI_REG_AUTOINC_EN when it is defined.
module tb_spi_reg_bridge;

  localparam logic [47:0] RST_VAL = 48'hA5A4_A3A2_A1A0;

  logic        clk;
  logic        rst;
  logic        ssel;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic [7:0]  response;
  logic [15:0] status_in;
  logic [47:0] reg_out;
  logic [5:0]  wr_strobe;

  int n_total;
  int n_bad;

  spi_reg_bridge #(.REG_RESET(RST_VAL)) dut (
    .clk       (clk),
    .rst       (rst),
    .ssel      (ssel),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .response  (response),
    .status_in (status_in),
    .reg_out   (reg_out),
    .wr_strobe (wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one byte for exactly one clock; returns at the negedge after it.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    cmd       = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    ssel = 1'b0;
    wait_cycles(4);
  endtask

  task automatic frame_end();
    @(negedge clk);
    ssel = 1'b1;
    wait_cycles(5);
  endtask

  logic [47:0] exp_regs;

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    ssel      = 1'b1;
    cmd       = 8'h00;
    cmd_valid = 1'b0;
    status_in = 16'hBEEF;
    exp_regs  = RST_VAL;

    // Reset state
    wait_cycles(3);
    check("rst_reg_out", reg_out, RST_VAL);
    check("rst_response", 48'(response), 48'h00);
    check("rst_strobe", 48'(wr_strobe), 48'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);

    // Write 5A to register 2
    frame_start();
    send_byte(8'h82);
    check("wr_cmd_resp", 48'(response), 48'h00);
    send_byte(8'h5A);
    exp_regs[23:16] = 8'h5A;
    check("wr_strobe_hi", 48'(wr_strobe), 48'h04);
    check("wr_reg2", reg_out, exp_regs);
    @(negedge clk);
    check("wr_strobe_lo", 48'(wr_strobe), 48'h0);
    frame_end();
    check("end_resp", 48'(response), 48'h00);

    // Read address 7 then one more byte (wraps to 0 with autoinc)
    frame_start();
    send_byte(8'h07);
    check("rd7_resp", 48'(response), 48'hBE);
    send_byte(8'h00);
`ifdef SPI_REG_AUTOINC_EN
    check("rd_wrap_resp", 48'(response), 48'hA0);
`else
    check("rd_after_resp", 48'(response), 48'h00);
`endif
    frame_end();

    // Malformed command is skipped
    frame_start();
    send_byte(8'h40);
    check("bad_cmd_resp", 48'(response), 48'hEE);
    send_byte(8'h55);
    check("skip_resp", 48'(response), 48'hEE);
    check("skip_strobe", 48'(wr_strobe), 48'h0);
    check("skip_regs", reg_out, exp_regs);
    frame_end();
    check("skip_end_resp", 48'(response), 48'h00);

    // Burst write 33, 44 starting at register 1
    frame_start();
    send_byte(8'h81);
    send_byte(8'h33);
    exp_regs[15:8] = 8'h33;
    check("burst_strobe1", 48'(wr_strobe), 48'h02);
    send_byte(8'h44);
`ifdef SPI_REG_AUTOINC_EN
    exp_regs[23:16] = 8'h44;
    check("burst_strobe2", 48'(wr_strobe), 48'h04);
`else
    check("burst_strobe2", 48'(wr_strobe), 48'h0);
`endif
    check("burst_regs", reg_out, exp_regs);
    frame_end();

    // Frame end coincident with a data byte: no write
    frame_start();
    send_byte(8'h83);
    ssel = 1'b1;
    wait_cycles(2);
    cmd       = 8'h77;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("race_strobe", 48'(wr_strobe), 48'h0);
    check("race_resp", 48'(response), 48'h00);
    check("race_regs", reg_out, exp_regs);
    wait_cycles(3);
    frame_start();
    send_byte(8'h03);
    check("race_idle_rd3", 48'(response), 48'hA3);
    frame_end();

    // Read address 6 (status low byte), next byte
    frame_start();
    send_byte(8'h06);
    check("rd6_resp", 48'(response), 48'hEF);
    send_byte(8'hFF);
`ifdef SPI_REG_AUTOINC_EN
    check("rd6_next_resp", 48'(response), 48'hBE);
`else
    check("rd6_next_resp", 48'(response), 48'h00);
`endif
    frame_end();

    // Write to read-only address 7 is ignored
    frame_start();
    send_byte(8'h87);
    send_byte(8'h12);
    check("ro_strobe", 48'(wr_strobe), 48'h0);
    check("ro_regs", reg_out, exp_regs);
    frame_end();

    // Reset in the middle of a write leaves nothing behind
    frame_start();
    send_byte(8'h84);
    cmd       = 8'h99;
    cmd_valid = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_rst_strobe", 48'(wr_strobe), 48'h0);
    check("mid_rst_regs", reg_out, RST_VAL);
    check("mid_rst_resp", 48'(response), 48'h00);
    rst = 1'b0;
    send_byte(8'h55);
    check("post_rst_strobe", 48'(wr_strobe), 48'h0);
    check("post_rst_regs", reg_out, RST_VAL);
    frame_end();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
